// File: rtl/fphub_pkg.sv
// rtl/fphub_pkg.sv - shared widths, beat type and shift helpers for the FPHUB normalizer
package fphub_pkg;

    localparam int M                   = 23;
    localparam int EXTRA_BITS_MANTISSA = 7;
    localparam int SIGN_MANTISSA_BIT   = 1;
    localparam int E                   = 8;
    localparam int MW                  = M + EXTRA_BITS_MANTISSA - SIGN_MANTISSA_BIT;
    localparam int SHIFT_WIDTH         = $clog2(MW - 1);

    // Shift-count MSB set means the LZD saw an all-zero magnitude.
    localparam logic [SHIFT_WIDTH:0] ZERO_SHIFT = {1'b1, {SHIFT_WIDTH{1'b0}}};
    localparam logic [SHIFT_WIDTH:0] MAX_SHIFT  = (SHIFT_WIDTH + 1)'(MW - 1);

    typedef struct packed {
        logic [MW-1:0] mant;
        logic [E-1:0]  exp;
        logic          sign;
        logic          zero;
        logic          uflow;
    } norm_beat_t;

    // A count beyond the magnitude width can only come from a zero magnitude.
    function automatic logic is_zero_shift(input logic [SHIFT_WIDTH:0] s);
        return ((s & ZERO_SHIFT) != '0) || (s > MAX_SHIFT);
    endfunction

endpackage

// File: rtl/fphub_normalizer_if.sv
// rtl/fphub_normalizer_if.sv - upstream/downstream handshake bundle of the normalizer
interface fphub_normalizer_if;
    import fphub_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [MW-1:0]          in_mant;
    logic [SHIFT_WIDTH:0]   in_shift_amt;
    logic [E-1:0]           in_exp;
    logic                   in_sign;

    logic                   out_valid;
    logic                   out_ready;
    logic [MW-1:0]          out_mant;
    logic [E-1:0]           out_exp;
    logic                   out_sign;
    logic                   out_zero;
    logic                   out_uflow;

    // Driver side: feeds input beats and consumes output beats.
    modport master (
        output in_valid, in_mant, in_shift_amt, in_exp, in_sign, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_uflow
    );

    // Normalizer side.
    modport slave (
        input  in_valid, in_mant, in_shift_amt, in_exp, in_sign, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_uflow
    );

endinterface

// File: rtl/fphub_lshift.sv
// rtl/fphub_lshift.sv - combinational logarithmic left barrel shifter, zero-filling LSBs
module fphub_lshift #(
    parameter int W  = 29,
    parameter int SW = 5
) (
    input  logic [W-1:0]  data_i,
    input  logic [SW-1:0] shift_i,
    output logic [W-1:0]  data_o
);

    logic [W-1:0] lvl [0:SW];

    assign lvl[0] = data_i;

    // Level k conditionally shifts by 2**k.
    for (genvar k = 0; k < SW; k++) begin : g_lvl
        assign lvl[k+1] = shift_i[k] ? (lvl[k] << (2 ** k)) : lvl[k];
    end

    assign data_o = lvl[SW];

endmodule

// File: rtl/fphub_normalizer.sv
// rtl/fphub_normalizer.sv - two-stage normalize/flush pipeline after the leading-zero detector
module fphub_normalizer
    import fphub_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fphub_normalizer_if.slave bus
);

    logic                   s1_valid_q, s1_valid_d;
    logic                   s2_valid_q, s2_valid_d;
    norm_beat_t             s1_q, s1_d;
    norm_beat_t             s2_q, s2_d;
    logic [SHIFT_WIDTH-1:0] s1_shift_q, s1_shift_d;

    logic                   adv1, adv2;
    logic                   in_zero;
    logic [E-1:0]           shift_ext;
    logic [MW-1:0]          shifted;

    assign adv2        = !s2_valid_q || bus.out_ready;
    assign adv1        = !s1_valid_q || adv2;
    assign bus.in_ready = adv1;

    assign in_zero   = is_zero_shift(bus.in_shift_amt);
    assign shift_ext = {{(E - SHIFT_WIDTH - 1){1'b0}}, bus.in_shift_amt};

    // Only the low bits matter: any count that sets the MSB is flushed as zero.
    fphub_lshift #(
        .W  (MW),
        .SW (SHIFT_WIDTH)
    ) u_lshift (
        .data_i  (s1_q.mant),
        .shift_i (s1_shift_q),
        .data_o  (shifted)
    );

    // Stage 1: capture the beat and precompute flags and adjusted exponent.
    always_comb begin
        s1_valid_d = adv1 ? bus.in_valid : s1_valid_q;
        s1_d       = s1_q;
        s1_shift_d = s1_shift_q;
        if (adv1 && bus.in_valid) begin
            s1_d.mant  = bus.in_mant;
            s1_d.exp   = bus.in_exp - shift_ext;
            s1_d.sign  = bus.in_sign;
            s1_d.zero  = in_zero;
            s1_d.uflow = !in_zero && (shift_ext >= bus.in_exp);
            s1_shift_d = bus.in_shift_amt[SHIFT_WIDTH-1:0];
        end
    end

    // Stage 2: apply the shift, or flush to +0 / signed underflow zero.
    always_comb begin
        s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
        s2_d       = s2_q;
        if (adv2 && s1_valid_q) begin
            s2_d = '0;
            if (s1_q.zero) begin
                s2_d.zero = 1'b1;
            end else if (s1_q.uflow) begin
                s2_d.sign  = s1_q.sign;
                s2_d.uflow = 1'b1;
            end else begin
                s2_d.mant = shifted;
                s2_d.exp  = s1_q.exp;
                s2_d.sign = s1_q.sign;
            end
        end
    end

    // Pipeline registers; reset discards any in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            s1_shift_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s1_shift_q <= s1_shift_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_mant  = s2_q.mant;
    assign bus.out_exp   = s2_q.exp;
    assign bus.out_sign  = s2_q.sign;
    assign bus.out_zero  = s2_q.zero;
    assign bus.out_uflow = s2_q.uflow;

endmodule

// File: tb/tb_fphub_normalizer.sv
// tb/tb_fphub_normalizer.sv - randomized and directed self-checking bench for fphub_normalizer
module tb_fphub_normalizer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fphub_normalizer_if bus ();

    fphub_normalizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_out  = 0;

    logic [39:0] exp_q [$];
    logic        stalled = 1'b0;
    logic [39:0] held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Reference: {mant[28:0], exp[7:0], sign, zero, uflow} from plain arithmetic.
    function automatic logic [39:0] model(input logic [28:0] m, input logic [5:0] s,
                                          input logic [7:0] e, input logic sg);
        int          sh;
        int          ex;
        logic [63:0] wide;
        logic [7:0]  eo;
        sh = int'(s);
        ex = int'(e);
        if (sh > 28) return {29'd0, 8'd0, 1'b0, 1'b1, 1'b0};
        if (sh >= ex) return {29'd0, 8'd0, sg, 1'b0, 1'b1};
        wide = 64'(m) << sh;
        eo   = 8'(ex - sh);
        return {wide[28:0], eo, sg, 2'b00};
    endfunction

    function automatic logic [39:0] dut_out();
        return {bus.out_mant, bus.out_exp, bus.out_sign, bus.out_zero, bus.out_uflow};
    endfunction

    // Scoreboard: predict on every accept, compare on every delivered beat, check stalls hold.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", 64'(bus.out_valid), 64'd1);
                chk("stall_data", 64'(dut_out()), 64'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    chk("beat", 64'(dut_out()), 64'(exp_q.pop_front()));
                end
                n_out++;
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_mant, bus.in_shift_amt, bus.in_exp, bus.in_sign));
            stalled = bus.out_valid && !bus.out_ready;
            held    = dut_out();
        end
    end

    task automatic rand_beat();
        int r;
        r = $urandom_range(0, 9);
        bus.in_mant = 29'($urandom);
        if (r == 0)      bus.in_shift_amt = 6'($urandom_range(32, 63));
        else if (r == 1) bus.in_shift_amt = 6'($urandom_range(29, 31));
        else             bus.in_shift_amt = 6'($urandom_range(0, 28));
        bus.in_exp  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
        bus.in_sign = 1'($urandom);
    endtask

    task automatic directed(input string nm, input logic [28:0] m, input logic [5:0] s,
                            input logic [7:0] e, input logic sg, input logic [39:0] want);
        int lat;
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_mant = m; bus.in_shift_amt = s;
        bus.in_exp = e; bus.in_sign = sg; bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            lat++;
        end
        chk(nm, 64'(dut_out()), 64'(want));
        chk({nm, "_latency"}, 64'(lat), 64'd2);
        @(posedge clk);
    endtask

    initial begin
        int idx;
        int start_out;
        bit saw_block;

        bus.in_valid = 1'b0; bus.in_mant = '0; bus.in_shift_amt = '0;
        bus.in_exp = '0; bus.in_sign = 1'b0; bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset_out_data", 64'(dut_out()), 64'd0);

        // Hand-computed expectations pin the model as well as the DUT.
        chk("model_basic", 64'(model(29'h0100_0000, 6'd4, 8'd130, 1'b1)),
            64'({29'h1000_0000, 8'd126, 3'b100}));
        directed("basic",  29'h0100_0000, 6'd4,        8'd130, 1'b1, {29'h1000_0000, 8'd126, 3'b100});
        directed("zero",   29'h0,         6'b100000,   8'd100, 1'b1, {29'h0, 8'd0, 3'b010});
        directed("uflow",  29'h0000_0008, 6'd25,       8'd20,  1'b1, {29'h0, 8'd0, 3'b101});
        directed("shift0", 29'h1FFF_FFFF, 6'd0,        8'd1,   1'b0, {29'h1FFF_FFFF, 8'd1, 3'b000});
        directed("shift28",29'h1,         6'd28,       8'd29,  1'b0, {29'h1000_0000, 8'd1, 3'b000});
        directed("shift28_uf", 29'h1,     6'd28,       8'd28,  1'b0, {29'h0, 8'd0, 3'b001});
        directed("over_mw", 29'h5,        6'd30,       8'd200, 1'b1, {29'h0, 8'd0, 3'b010});

        // Back-pressure: five beats, sink stalled for cycles 3..6.
        start_out = n_out; idx = 0; saw_block = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            bus.out_ready = !(cyc >= 3 && cyc <= 6);
            bus.in_valid  = (idx < 5);
            rand_beat();
            @(negedge clk);
            if (!bus.in_ready) saw_block = 1;
            if (bus.in_valid && bus.in_ready) idx++;
        end
        @(posedge clk); #1 bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        chk("bp_in_ready_dropped", 64'(saw_block), 64'd1);
        chk("bp_beats_in", 64'(idx), 64'd5);
        chk("bp_beats_out", 64'(n_out - start_out), 64'd5);

        // Random traffic with random back-pressure.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rand_beat();
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            rand_beat();
            @(negedge clk);
            if (!bus.in_ready) break;
        end
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1; bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        start_out = n_out;
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rst_no_stale", 64'(n_out - start_out), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fphub_normalizer.md
Name: fphub_normalizer

Overview:
- Normalization stage directly downstream of the leading-zero detector in the FPHUB adder datapath.
- Consumes:
  - the magnitude of the aligned-mantissa difference;
  - the leading-zero count for that magnitude;
  - the tentative result exponent and sign.
- Left-shifts the mantissa so its MSB is 1, decrements the exponent, and detects zero and underflow (flush-to-zero).
- Two-stage valid/ready pipeline that feeds the HUB pack/round stage.

Parameters:
- M, 23, stored mantissa width.
- extra_bits_mantissa, 7, guard/extension bits carried through the adder.
- sign_mantissa_bit, 1, sign bit removed before magnitude processing.
- E, 8, exponent width.
- MW, M+extra_bits_mantissa-sign_mantissa_bit, magnitude width (29 by default). Derived; not overridden.
- SHIFT_WIDTH, $clog2(MW-1), shift-count width minus one (5 by default). Derived.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_mant  in  MW  |A-B| magnitude
- in_shift_amt  in  SHIFT_WIDTH+1  leading-zero count; MSB set = magnitude is zero
- in_exp  in  E  tentative exponent (biased)
- in_sign  in  1  tentative sign
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_mant  out  MW  normalized magnitude, bit MW-1 = 1 unless zero
- out_exp  out  E  adjusted exponent
- out_sign  out  1  result sign
- out_zero  out  1  exact-zero result
- out_uflow  out  1  underflow flushed to zero

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: all valid bits 0; all output data registers 0; in_ready = 1 in the first cycle after reset.
- Handshake:
  - A beat transfers when valid&&ready on the same edge.
  - out_* data holds stable while out_valid && !out_ready.
  - in_ready is not a function of in_valid.
- Pipeline:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1.
- Stage 1 (on accept):
  - Register mant, shift, exp, sign.
  - Compute flags:
    - zero = in_shift_amt[SHIFT_WIDTH] || (in_shift_amt > MW-1).
    - uflow = !zero && (in_shift_amt >= in_exp), compared at E bits after zero-extension.
  - Compute exp_adj = in_exp - in_shift_amt.
- Stage 2 (on adv2 with s1_valid):
  - mant = s1_mant << s1_shift, zero-filled LSBs.
  - If zero: mant = 0, exp = 0, sign = 0 (+0 result).
  - If uflow: mant = 0, exp = 0, sign kept, uflow = 1.
  - Otherwise: exp = exp_adj; zero = 0 and uflow = 0.
- Valid-bit updates:
  - s1_valid is cleared when adv1 is set and no new beat arrives.
  - s2_valid is cleared when out_ready is set and s1_valid = 0.
- Latency and throughput:
  - 2 cycles from accept to out_valid with no back-pressure.
  - Throughput is 1 beat per cycle.
  - Full occupancy is 2 beats; with out_ready = 0 and both stages full, in_ready = 0.
- Simultaneous events: accept into stage 1 and drain of stage 2 in the same cycle is legal and loses no beats.
- Reset mid-operation: in-flight beats are discarded with no partial output.
- Shift-amount boundaries:
  - in_shift_amt = 0: mantissa passes unchanged, exponent unchanged.
  - in_shift_amt = MW-1: only LSB set at input, which becomes the MSB.
- Ordering: beats emerge in acceptance order.

Decomposition:
- Package fphub_pkg holds:
  - E and MW defaults;
  - typedef norm_beat_t (mant, exp, sign, zero, uflow) used for the stage registers;
  - localparam ZERO_SHIFT = {1'b1, {SHIFT_WIDTH{1'b0}}}.
- Sub-module fphub_lshift: combinational MW-bit logarithmic left barrel shifter (SHIFT_WIDTH levels). Reusable by the pack stage.

Test Plan:
- Basic normalize:
  - Stimulus: in_mant = 29'h0100_0000, shift = 4, exp = 130, sign = 1, out_ready = 1.
  - Required: 2 cycles later out_mant = 29'h1000_0000, exp = 126, sign = 1, zero = 0, uflow = 0.
- Zero result:
  - Stimulus: in_mant = 0, shift = 6'b100000, exp = 100, sign = 1.
  - Required: out_mant = 0, exp = 0, sign = 0, zero = 1.
- Underflow:
  - Stimulus: in_mant = 29'h0000_0008, shift = 25, exp = 20.
  - Required: out_mant = 0, exp = 0, uflow = 1, sign preserved.
- Boundaries:
  - Stimulus 1: shift = 0, mant = 29'h1FFF_FFFF, exp = 1. Required: output identical, exp = 1.
  - Stimulus 2: shift = 28, mant = 1, exp = 29. Required: out_mant = 29'h1000_0000, exp = 1.
  - Stimulus 3: shift = 28, mant = 1, exp = 28. Required: uflow = 1.
- Back-pressure:
  - Stimulus: stream 5 beats with out_ready = 0 for cycles 3-6.
  - Required: in_ready drops after 2 beats are held; out_* stable while stalled; all 5 beats delivered in order with none duplicated.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle with both stages full.
  - Required: out_valid = 0 and in_ready = 1 the next cycle; no stale beat emitted afterwards.
